// File: rtl/controlador_acceso_param_pkg.sv
// Shared definitions for the parking-gate access controller:
// state encoding, BCD digit check and the factory PIN.
package acceso_pkg;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    PIN        = 3'd1,
    ABIERTO    = 3'd2,
    PASANDO    = 3'd3,
    ALARMA_PIN = 3'd4,
    BLOQUEO    = 3'd5
  } estado_t;

  // Factory PIN loaded on reset (zero-extended to the PIN width)
  localparam logic [15:0] CLAVE_DEFECTO = 16'h2468;

  // A 4-bit nibble is a legal BCD digit when it is 0..9
  function automatic logic digito_bcd_valido(input logic [3:0] digito);
    return (digito <= 4'd9);
  endfunction

endpackage

// File: rtl/controlador_acceso_param_if.sv
// Sensor / keypad / actuator bundle between the environment and the controller.
interface controlador_acceso_param_if #(
  parameter int N_DIGITOS    = 4,
  parameter int MAX_INTENTOS = 3
);
  localparam int W  = 4 * N_DIGITOS;
  localparam int CW = $clog2(MAX_INTENTOS + 1);

  logic          llegado_vehiculo;
  logic [W-1:0]  clave_ingresada;
  logic          clave_valida;
  logic          paso_vehiculo;
  logic          boton_reset;
  logic          programar_clave;
  logic [W-1:0]  clave_nueva;
  logic          abriendo_compuerta;
  logic          cerrando_compuerta;
  logic          alarm_pin_incorrecto;
  logic          alarm_bloqueo;
  logic [CW-1:0] intentos;
  logic          error_bcd;

  // Environment side: drives sensors and keypad, observes the gate
  modport master (
    output llegado_vehiculo, clave_ingresada, clave_valida, paso_vehiculo,
           boton_reset, programar_clave, clave_nueva,
    input  abriendo_compuerta, cerrando_compuerta, alarm_pin_incorrecto,
           alarm_bloqueo, intentos, error_bcd
  );

  // Controller side
  modport slave (
    input  llegado_vehiculo, clave_ingresada, clave_valida, paso_vehiculo,
           boton_reset, programar_clave, clave_nueva,
    output abriendo_compuerta, cerrando_compuerta, alarm_pin_incorrecto,
           alarm_bloqueo, intentos, error_bcd
  );

endinterface

// File: rtl/controlador_acceso_param_comparador.sv
// Combinational PIN checker: flags whether every digit of clave is BCD and
// whether clave equals the reference word over the full width.
module comparador_bcd
  import acceso_pkg::*;
#(
  parameter int N_DIGITOS = 4
) (
  input  logic [4*N_DIGITOS-1:0] clave,
  input  logic [4*N_DIGITOS-1:0] referencia,
  output logic                   valida,
  output logic                   igual
);

  logic [N_DIGITOS-1:0] w_digito_ok;

  // One validity check per BCD digit
  for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_digito
    assign w_digito_ok[gi] = digito_bcd_valido(clave[4*gi +: 4]);
  end

  assign valida = &w_digito_ok;
  assign igual  = (clave == referencia);

endmodule

// File: rtl/controlador_acceso_param.sv
// Parametrised parking-gate access controller: PIN entry with attempt limit,
// run-time programmable PIN, open-gate timeout and tailgating lock-out.
module controlador_acceso_param
  import acceso_pkg::*;
#(
  parameter int          N_DIGITOS         = 4,
  parameter int          MAX_INTENTOS      = 3,
  parameter int          T_APERTURA        = 64,
  parameter logic [15:0] CLAVE_POR_DEFECTO = CLAVE_DEFECTO
) (
  input logic                       clk,
  input logic                       reset,
  controlador_acceso_param_if.slave bus
);

  localparam int W     = 4 * N_DIGITOS;
  localparam int CW    = $clog2(MAX_INTENTOS + 1);
  localparam int CNT_W = $clog2(T_APERTURA);

  localparam logic [CW-1:0]    INTENTOS_MAX = CW'(MAX_INTENTOS);
  localparam logic [CNT_W-1:0] CNT_FIN      = CNT_W'(T_APERTURA - 1);

  estado_t          r_estado;
  logic [W-1:0]     r_clave;
  logic [CNT_W-1:0] r_contador;
  logic [CW-1:0]    r_intentos;
  logic             r_abriendo;
  logic             r_cerrando;
  logic             r_alarm_pin;
  logic             r_alarm_bloqueo;
  logic             r_error_bcd;

  logic             w_pin_valida;
  logic             w_pin_igual;
  logic             w_nueva_valida;
  logic             w_nueva_igual;
  logic             w_pin_correcto;
  logic [CW-1:0]    w_intentos_mas1;

  // Keypad word against the stored PIN
  comparador_bcd #(.N_DIGITOS(N_DIGITOS)) u_cmp_pin (
    .clave      (bus.clave_ingresada),
    .referencia (r_clave),
    .valida     (w_pin_valida),
    .igual      (w_pin_igual)
  );

  // New PIN validation; equality lets reprogramming the same PIN be a no-op
  comparador_bcd #(.N_DIGITOS(N_DIGITOS)) u_cmp_nueva (
    .clave      (bus.clave_nueva),
    .referencia (r_clave),
    .valida     (w_nueva_valida),
    .igual      (w_nueva_igual)
  );

  assign w_pin_correcto  = w_pin_valida & w_pin_igual;
  assign w_intentos_mas1 = (r_intentos == INTENTOS_MAX) ? r_intentos : r_intentos + 1'b1;

  // Main FSM with registered Moore outputs and one-cycle pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado        <= ESPERA;
      r_clave         <= W'(CLAVE_POR_DEFECTO);
      r_contador      <= '0;
      r_intentos      <= '0;
      r_abriendo      <= 1'b0;
      r_cerrando      <= 1'b0;
      r_alarm_pin     <= 1'b0;
      r_alarm_bloqueo <= 1'b0;
      r_error_bcd     <= 1'b0;
    end else begin
      r_cerrando  <= 1'b0;
      r_error_bcd <= 1'b0;
      case (r_estado)
        ESPERA: begin
          if (bus.boton_reset) r_intentos <= '0;
          if (bus.programar_clave) begin
            if (!w_nueva_valida)     r_error_bcd <= 1'b1;
            else if (!w_nueva_igual) r_clave     <= bus.clave_nueva;
          end
          if (bus.llegado_vehiculo) r_estado <= PIN;
        end
        PIN: begin
          if (bus.clave_valida) begin
            if (!w_pin_valida) r_error_bcd <= 1'b1;
            if (w_pin_correcto) begin
              r_estado   <= ABIERTO;
              r_abriendo <= 1'b1;
              r_contador <= '0;
              r_intentos <= '0;
            end else begin
              r_intentos <= w_intentos_mas1;
              if (w_intentos_mas1 == INTENTOS_MAX) begin
                r_estado    <= ALARMA_PIN;
                r_alarm_pin <= 1'b1;
              end
            end
          end else if (!bus.llegado_vehiculo) begin
            r_estado <= ESPERA;
          end
          // Button clears after the strobe has been evaluated (last write wins)
          if (bus.boton_reset) r_intentos <= '0;
        end
        ABIERTO: begin
          if (bus.paso_vehiculo && bus.llegado_vehiculo) begin
            r_estado        <= BLOQUEO;
            r_abriendo      <= 1'b0;
            r_alarm_bloqueo <= 1'b1;
            r_contador      <= '0;
          end else if (bus.paso_vehiculo) begin
            r_estado   <= PASANDO;
            r_contador <= '0;
          end else if (r_contador == CNT_FIN) begin
            r_estado   <= ESPERA;
            r_abriendo <= 1'b0;
            r_cerrando <= 1'b1;
            r_contador <= '0;
          end else begin
            r_contador <= r_contador + 1'b1;
          end
        end
        PASANDO: begin
          if (bus.paso_vehiculo && bus.llegado_vehiculo) begin
            r_estado        <= BLOQUEO;
            r_abriendo      <= 1'b0;
            r_alarm_bloqueo <= 1'b1;
          end else if (!bus.paso_vehiculo) begin
            r_estado   <= ESPERA;
            r_abriendo <= 1'b0;
            r_cerrando <= 1'b1;
          end
        end
        ALARMA_PIN: begin
          if (bus.boton_reset) begin
            r_estado    <= ESPERA;
            r_alarm_pin <= 1'b0;
            r_intentos  <= '0;
          end
        end
        BLOQUEO: begin
          if (bus.clave_valida) begin
            if (!w_pin_valida) r_error_bcd <= 1'b1;
            if (w_pin_correcto) begin
              r_estado        <= ESPERA;
              r_alarm_bloqueo <= 1'b0;
            end
          end
        end
        default: r_estado <= ESPERA;
      endcase
    end
  end

  assign bus.abriendo_compuerta   = r_abriendo;
  assign bus.cerrando_compuerta   = r_cerrando;
  assign bus.alarm_pin_incorrecto = r_alarm_pin;
  assign bus.alarm_bloqueo        = r_alarm_bloqueo;
  assign bus.intentos             = r_intentos;
  assign bus.error_bcd            = r_error_bcd;

endmodule

// File: tb/tb_controlador_acceso_param.sv
// Directed self-checking bench for controlador_acceso_param (default parameters).
module tb_controlador_acceso_param;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  controlador_acceso_param_if #(.N_DIGITOS(4), .MAX_INTENTOS(3)) bus ();

  controlador_acceso_param #(
    .N_DIGITOS(4), .MAX_INTENTOS(3), .T_APERTURA(64), .CLAVE_POR_DEFECTO(16'h2468)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle keypad strobe
  task automatic strobe(input logic [15:0] pin);
    bus.clave_ingresada = pin;
    bus.clave_valida    = 1'b1;
    step();
    bus.clave_valida    = 1'b0;
  endtask

  // Vehicle passes from ABIERTO and the gate closes
  task automatic pasar(input string tag);
    bus.llegado_vehiculo = 1'b0;
    bus.paso_vehiculo    = 1'b1;
    step();
    bus.paso_vehiculo    = 1'b0;
    step();
    chk({tag, "_cp"}, 32'(bus.cerrando_compuerta), 32'd1);
    step();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    bus.llegado_vehiculo = 1'b0;
    bus.clave_ingresada  = '0;
    bus.clave_valida     = 1'b0;
    bus.paso_vehiculo    = 1'b0;
    bus.boton_reset      = 1'b0;
    bus.programar_clave  = 1'b0;
    bus.clave_nueva      = '0;
    #12;
    chk("reset_outs", {26'd0, bus.abriendo_compuerta, bus.cerrando_compuerta,
        bus.alarm_pin_incorrecto, bus.alarm_bloqueo, bus.error_bcd, 1'b0}, 32'd0);
    chk("reset_intentos", 32'(bus.intentos), 32'd0);
    #10 reset = 1'b1;
    step();

    // Normal entry
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h2468);
    chk("normal_ac", 32'(bus.abriendo_compuerta), 32'd1);
    bus.llegado_vehiculo = 1'b0; bus.paso_vehiculo = 1'b1; step();
    chk("pasando_ac", 32'(bus.abriendo_compuerta), 32'd1);
    bus.paso_vehiculo = 1'b0; step();
    chk("normal_cp", 32'(bus.cerrando_compuerta), 32'd1);
    chk("normal_ac_off", 32'(bus.abriendo_compuerta), 32'd0);
    step();
    chk("normal_cp_1cyc", 32'(bus.cerrando_compuerta), 32'd0);

    // Wrong PINs then correct
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h1234);
    strobe(16'h1234);
    chk("wrong_intentos", 32'(bus.intentos), 32'd2);
    chk("wrong_ac", 32'(bus.abriendo_compuerta), 32'd0);
    strobe(16'h2468);
    chk("retry_ac", 32'(bus.abriendo_compuerta), 32'd1);
    chk("retry_intentos", 32'(bus.intentos), 32'd0);
    pasar("retry");

    // Alarm after three wrong attempts
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h1111); strobe(16'h2222); strobe(16'h3333);
    chk("alarm_ai", 32'(bus.alarm_pin_incorrecto), 32'd1);
    chk("alarm_intentos", 32'(bus.intentos), 32'd3);
    strobe(16'h2468);
    chk("alarm_ignores_pin", 32'(bus.abriendo_compuerta), 32'd0);
    bus.boton_reset = 1'b1; step(); bus.boton_reset = 1'b0;
    chk("alarm_br_ai", 32'(bus.alarm_pin_incorrecto), 32'd0);
    chk("alarm_br_intentos", 32'(bus.intentos), 32'd0);

    // Tailgate: LV still high, ESPERA -> PIN
    step();
    strobe(16'h2468);
    bus.paso_vehiculo = 1'b1; step(); bus.paso_vehiculo = 1'b0;
    chk("tail_ab", 32'(bus.alarm_bloqueo), 32'd1);
    chk("tail_ac", 32'(bus.abriendo_compuerta), 32'd0);
    bus.boton_reset = 1'b1; step(); bus.boton_reset = 1'b0;
    chk("tail_br_ab", 32'(bus.alarm_bloqueo), 32'd1);
    strobe(16'h1234);
    chk("tail_wrong_ab", 32'(bus.alarm_bloqueo), 32'd1);
    chk("tail_wrong_intentos", 32'(bus.intentos), 32'd0);
    strobe(16'h2468);
    chk("tail_ok_ab", 32'(bus.alarm_bloqueo), 32'd0);
    bus.llegado_vehiculo = 1'b0; step();

    // Programming a new PIN
    bus.programar_clave = 1'b1; bus.clave_nueva = 16'h1194; step();
    bus.programar_clave = 1'b0;
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h2468);
    chk("prog_old_ac", 32'(bus.abriendo_compuerta), 32'd0);
    chk("prog_old_intentos", 32'(bus.intentos), 32'd1);
    strobe(16'h1194);
    chk("prog_new_ac", 32'(bus.abriendo_compuerta), 32'd1);
    pasar("prog");

    // Invalid BCD programming
    bus.programar_clave = 1'b1; bus.clave_nueva = 16'h12A4; step();
    bus.programar_clave = 1'b0;
    chk("prog_bcd_err", 32'(bus.error_bcd), 32'd1);
    step();
    chk("prog_bcd_err_1cyc", 32'(bus.error_bcd), 32'd0);
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h1194);
    chk("prog_keep_ac", 32'(bus.abriendo_compuerta), 32'd1);
    pasar("keep");

    // Invalid BCD strobe counts as wrong attempt
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h9F00);
    chk("pin_bcd_err", 32'(bus.error_bcd), 32'd1);
    chk("pin_bcd_intentos", 32'(bus.intentos), 32'd1);
    bus.llegado_vehiculo = 1'b0; step();
    bus.boton_reset = 1'b1; step(); bus.boton_reset = 1'b0;
    chk("br_espera_intentos", 32'(bus.intentos), 32'd0);

    // Timeout: gate open for exactly 64 cycles
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h1194);
    for (int i = 0; i < 63; i++) step();
    chk("timeout_still_open", 32'(bus.abriendo_compuerta), 32'd1);
    step();
    chk("timeout_ac", 32'(bus.abriendo_compuerta), 32'd0);
    chk("timeout_cp", 32'(bus.cerrando_compuerta), 32'd1);
    bus.llegado_vehiculo = 1'b0; step();

    // Asynchronous reset while open; PIN reverts to default
    bus.llegado_vehiculo = 1'b1; step();
    strobe(16'h1194);
    chk("pre_reset_ac", 32'(bus.abriendo_compuerta), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_ac", 32'(bus.abriendo_compuerta), 32'd0);
    #2 reset = 1'b1;
    step();
    strobe(16'h2468);
    chk("reset_default_pin", 32'(bus.abriendo_compuerta), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
